// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, BEQ
// resolution and the EX/MEM pipeline register.
module execute_stage #(
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                RegWriteE,
   input  logic                ALUSrcE,
   input  logic                MemWriteE,
   input  logic                ResultSrcE,
   input  logic                BranchE,
   input  logic [2:0]          ALUControlE,
   input  logic [DATA_W-1:0]   RD1_E,
   input  logic [DATA_W-1:0]   RD2_E,
   input  logic [DATA_W-1:0]   Imm_Ext_E,
   input  logic [4:0]          RD_E,
   input  logic [DATA_W-1:0]   PCE,
   input  logic [DATA_W-1:0]   PCPlus4E,
   input  logic [1:0]          ForwardAE,
   input  logic [1:0]          ForwardBE,
   input  logic [DATA_W-1:0]   ResultW,
   input  logic                FlushM,
   output logic                PCSrcE,
   output logic [DATA_W-1:0]   PCTargetE,
   output logic                RegWriteM,
   output logic                MemWriteM,
   output logic                ResultSrcM,
   output logic [DATA_W-1:0]   ALUResultM,
   output logic [DATA_W-1:0]   WriteDataM,
   output logic [4:0]          RD_M,
   output logic [DATA_W-1:0]   PCPlus4M
);

   localparam int unsigned REG_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic [DATA_W-1:0] write_data_e;
   logic [DATA_W-1:0] alu_result_e;
   logic              zero_e;

   // Operand A forwarding mux; code 11 falls back to the register file.
   always_comb begin
      src_a = RD1_E;
      case (ForwardAE)
         FWD_WB:  src_a = ResultW;
         FWD_MEM: src_a = ALUResultM;
         default: src_a = RD1_E;
      endcase
   end

   // Operand B forwarding mux; its output is also the store data.
   always_comb begin
      write_data_e = RD2_E;
      case (ForwardBE)
         FWD_WB:  write_data_e = ResultW;
         FWD_MEM: write_data_e = ALUResultM;
         default: write_data_e = RD2_E;
      endcase
   end

   assign src_b = ALUSrcE ? Imm_Ext_E : write_data_e;

   // ALU; unused encodings produce zero.
   always_comb begin
      alu_result_e = '0;
      case (ALUControlE)
         ALU_ADD: alu_result_e = src_a + src_b;
         ALU_SUB: alu_result_e = src_a - src_b;
         ALU_AND: alu_result_e = src_a & src_b;
         ALU_OR:  alu_result_e = src_a | src_b;
         ALU_SLT: alu_result_e = ($signed(src_a) < $signed(src_b)) ? DATA_W'(1) : '0;
         default: alu_result_e = '0;
      endcase
   end

   assign zero_e    = (alu_result_e == '0);
   assign PCSrcE    = BranchE & zero_e;
   assign PCTargetE = PCE + Imm_Ext_E;

   // EX/MEM register: flush inserts a bubble, reset clears asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= 1'b0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         RD_M       <= '0;
         PCPlus4M   <= '0;
      end else if (FlushM) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= 1'b0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         RD_M       <= '0;
         PCPlus4M   <= '0;
      end else begin
         RegWriteM  <= RegWriteE;
         MemWriteM  <= MemWriteE;
         ResultSrcM <= ResultSrcE;
         ALUResultM <= alu_result_e;
         WriteDataM <= write_data_e;
         RD_M       <= REG_W'(RD_E);
         PCPlus4M   <= PCPlus4E;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table plus reset/flush sequences.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        FlushM;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RD_M;

   int n_vec = 0;
   int n_err = 0;

   execute_stage #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW), .FlushM(FlushM),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RD_M(RD_M),
      .PCPlus4M(PCPlus4M)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  ctl;
      logic        alusrc;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        br;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] resw;
      logic [31:0] pce;
      logic [31:0] exp_alu;
      logic [31:0] exp_wd;
      logic [31:0] exp_tgt;
      logic        exp_pcsrc;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
      ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
      PCE = 0; PCPlus4E = 4; ForwardAE = 0; ForwardBE = 0; ResultW = 0; FlushM = 0;
   endtask

   task automatic check_m_zero(input string tag);
      check({tag, " RegWriteM"},  32'(RegWriteM),  32'h0);
      check({tag, " MemWriteM"},  32'(MemWriteM),  32'h0);
      check({tag, " ResultSrcM"}, 32'(ResultSrcM), 32'h0);
      check({tag, " ALUResultM"}, ALUResultM,      32'h0);
      check({tag, " WriteDataM"}, WriteDataM,      32'h0);
      check({tag, " RD_M"},       32'(RD_M),       32'h0);
      check({tag, " PCPlus4M"},   PCPlus4M,        32'h0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      //            ctl     src fa     fb     br rd1           rd2           imm           resw      pce           alu           wd            tgt           pcsrc
      vecs[0]  = '{3'b001, 0, 2'b00, 2'b00, 0, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h0,    32'h200,      32'hFFFFFFFB, 32'h3,        32'h200,      0};
      vecs[1]  = '{3'b101, 0, 2'b00, 2'b00, 0, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h0,    32'h200,      32'h1,        32'h3,        32'h200,      0};
      vecs[2]  = '{3'b010, 0, 2'b00, 2'b00, 0, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h0,    32'h200,      32'h2,        32'h3,        32'h200,      0};
      vecs[3]  = '{3'b011, 0, 2'b00, 2'b00, 0, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h0,    32'h200,      32'hFFFFFFFF, 32'h3,        32'h200,      0};
      vecs[4]  = '{3'b110, 0, 2'b00, 2'b00, 0, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h0,    32'h200,      32'h0,        32'h3,        32'h200,      0};
      vecs[5]  = '{3'b100, 0, 2'b00, 2'b00, 0, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h0,    32'h200,      32'h0,        32'h3,        32'h200,      0};
      vecs[6]  = '{3'b111, 0, 2'b00, 2'b00, 0, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h0,    32'h200,      32'h0,        32'h3,        32'h200,      0};
      vecs[7]  = '{3'b000, 0, 2'b00, 2'b00, 1, 32'hFFFFFFFF, 32'h1,        32'h10,       32'h0,    32'h40,       32'h0,        32'h1,        32'h50,       1};
      vecs[8]  = '{3'b101, 0, 2'b00, 2'b00, 0, 32'h3,        32'hFFFFFFFE, 32'h0,        32'h0,    32'h0,        32'h0,        32'hFFFFFFFE, 32'h0,        0};
      vecs[9]  = '{3'b000, 0, 2'b00, 2'b00, 0, 32'h8,        32'hC,        32'h0,        32'h0,    32'h0,        32'h14,       32'hC,        32'h0,        0};
      vecs[10] = '{3'b001, 0, 2'b10, 2'b01, 0, 32'hDEAD,     32'hBEEF,     32'h0,        32'h3,    32'h0,        32'h11,       32'h3,        32'h0,        0};
      vecs[11] = '{3'b000, 0, 2'b11, 2'b00, 0, 32'h4,        32'h1,        32'h0,        32'h64,   32'h0,        32'h5,        32'h1,        32'h0,        0};
      vecs[12] = '{3'b011, 0, 2'b01, 2'b11, 0, 32'h0,        32'hF,        32'h0,        32'hF0,   32'h0,        32'hFF,       32'hF,        32'h0,        0};
      vecs[13] = '{3'b001, 0, 2'b00, 2'b00, 1, 32'h9,        32'h9,        32'hFFFFFFF0, 32'h0,    32'h100,      32'h0,        32'h9,        32'hF0,       1};
      vecs[14] = '{3'b001, 0, 2'b00, 2'b00, 1, 32'h9,        32'h8,        32'hFFFFFFF0, 32'h0,    32'h100,      32'h1,        32'h8,        32'hF0,       0};
      vecs[15] = '{3'b000, 1, 2'b00, 2'b00, 0, 32'h1000,     32'hAB,       32'h4,        32'h0,    32'h300,      32'h1004,     32'hAB,       32'h304,      0};
      vecs[16] = '{3'b001, 0, 2'b00, 2'b10, 0, 32'h2000,     32'h77,       32'h0,        32'h0,    32'h0,        32'hFFC,      32'h1004,     32'h0,        0};

      // Reset held with inputs toggling: M outputs stay zero, PCTargetE follows inputs.
      idle_inputs();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1;
         RD1_E = $urandom; RD2_E = $urandom; RD_E = 5'(k + 3);
         PCE = 32'h1000 * (k + 1); Imm_Ext_E = 32'h8; PCPlus4E = PCE + 4;
         @(posedge clk); #1;
      end
      check_m_zero("reset_hold");
      check("reset_hold PCTargetE", PCTargetE, 32'h4008);

      // Release reset and apply ADD 5 + 7.
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      RegWriteE = 1; RD1_E = 5; RD2_E = 7; RD_E = 5'd3; PCPlus4E = 32'h24;
      @(posedge clk); #1;
      check("first_add ALUResultM", ALUResultM, 32'd12);
      check("first_add RegWriteM", 32'(RegWriteM), 32'h1);
      check("first_add PCPlus4M", PCPlus4M, 32'h24);

      // Table-driven vectors, applied back to back.
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         idle_inputs();
         ALUControlE = vecs[i].ctl; ALUSrcE = vecs[i].alusrc;
         ForwardAE = vecs[i].fa; ForwardBE = vecs[i].fb; BranchE = vecs[i].br;
         RD1_E = vecs[i].rd1; RD2_E = vecs[i].rd2; Imm_Ext_E = vecs[i].imm;
         ResultW = vecs[i].resw; PCE = vecs[i].pce; PCPlus4E = vecs[i].pce + 4;
         RegWriteE = 1; MemWriteE = vecs[i].alusrc; ResultSrcE = i[1]; RD_E = 5'(i + 1);
         #1;
         check($sformatf("v%0d PCSrcE", i), 32'(PCSrcE), 32'(vecs[i].exp_pcsrc));
         check($sformatf("v%0d PCTargetE", i), PCTargetE, vecs[i].exp_tgt);
         @(posedge clk); #1;
         check($sformatf("v%0d ALUResultM", i), ALUResultM, vecs[i].exp_alu);
         check($sformatf("v%0d WriteDataM", i), WriteDataM, vecs[i].exp_wd);
         check($sformatf("v%0d RegWriteM", i), 32'(RegWriteM), 32'h1);
         check($sformatf("v%0d MemWriteM", i), 32'(MemWriteM), 32'(vecs[i].alusrc));
         check($sformatf("v%0d ResultSrcM", i), 32'(ResultSrcM), 32'(i[1]));
         check($sformatf("v%0d RD_M", i), 32'(RD_M), 32'(i + 1));
         check($sformatf("v%0d PCPlus4M", i), PCPlus4M, vecs[i].pce + 32'h4);
      end

      // Flush: bubble loaded despite valid controls.
      @(negedge clk);
      idle_inputs();
      RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 5'd9;
      RD1_E = 32'h55; RD2_E = 32'h66; PCPlus4E = 32'h80; FlushM = 1;
      @(posedge clk); #1;
      check_m_zero("flush");

      // Flush released: the same instruction now captures.
      @(negedge clk);
      FlushM = 0;
      @(posedge clk); #1;
      check("unflush ALUResultM", ALUResultM, 32'hBB);
      check("unflush RegWriteM", 32'(RegWriteM), 32'h1);
      check("unflush RD_M", 32'(RD_M), 32'd9);

      // Async reset between edges clears outputs without a clock edge.
      #2;
      rst = 1'b0;
      #1;
      check_m_zero("async_rst");
      check("async_rst PCTargetE", PCTargetE, 32'h0);

      // Release mid-cycle: nothing captured until the next rising edge.
      @(negedge clk);
      #1;
      rst = 1'b1;
      #2;
      check("post_release RegWriteM", 32'(RegWriteM), 32'h0);
      @(posedge clk); #1;
      check("post_release_edge RegWriteM", 32'(RegWriteM), 32'h1);
      check("post_release_edge ALUResultM", ALUResultM, 32'hBB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
